buzz_arbiter: RTL and testbench
===============================

Name: buzz_arbiter

Overview:
- Front-end lock-in stage of the four-person quiz responder; sits directly upstream of the score recorder.
- Samples the four contestant buttons and grants exactly one contestant per question. Drives the one-hot answer-valid hold signals en_s0..en_s3 that the recorder consumes.
- Runs buzz-window and answer-window countdowns, flags early presses (fouls), and releases the grant when the recorder raises its judged interrupt zd_r or the answer window expires.

Parameters:
- TICK_DIV, 1000: clk_count cycles per countdown tick (1 s at 1 kHz); must be >= 2.
- BUZZ_TIME, 20: ticks allowed between start and first valid press; range 1..31.
- ANSWER_TIME, 10: ticks allowed for answering once granted; range 1..31.

Ports:
- clk_count  in  1  system clock
- rst  in  1  reset
- start  in  1  host "begin question" level/pulse; acted on at rising edge
- s0, s1, s2, s3  in  1 each  raw contestant buttons, asynchronous, active-high
- zd_r  in  1  judged interrupt from score recorder
- en_s0, en_s1, en_s2, en_s3  out  1 each  one-hot answer-valid hold
- winner  out  2  index of granted contestant; valid while any en_sX=1
- foul  out  4  per-contestant early-press flags
- time_left  out  5  remaining ticks of the active window
- busy  out  1  high in ARMED or LOCKED
- timeout  out  1  one-cycle pulse on window expiry

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: all en_sX=0, winner=0, foul=0, time_left=0, busy=0, timeout=0, state IDLE. Reset mid-question aborts immediately.
- Inputs s0..s3 and start pass through a 2-flop synchronizer and then a rising-edge detector. Press latency to action is 3 clk_count edges. Holding a button never re-triggers.
- tick is a one-cycle pulse every TICK_DIV cycles. The divider is cleared on every state entry, so the first tick lands exactly TICK_DIV cycles after entry.
- IDLE:
  - busy=0; time_left=0.
  - A press edge on contestant i sets foul[i]=1; foul bits are sticky.
  - start edge -> ARMED; time_left=BUZZ_TIME; foul is NOT cleared.
- ARMED:
  - busy=1.
  - Eligible contestants are those with a press edge and foul[i]=0. Fouled contestants are locked out for this question.
  - If any contestant is eligible -> LOCKED. Lowest index wins on a same-cycle tie. winner=i; en_si=1 in the next cycle; time_left=ANSWER_TIME.
  - On tick, time_left decrements. A tick that brings time_left to 0 -> timeout pulse, IDLE. A press in the same cycle as that expiring tick wins over expiry.
  - A start edge in ARMED is ignored.
- LOCKED:
  - busy=1; en_s[winner]=1, all others 0. Held stable until exit.
  - zd_r=1 -> IDLE. en drops on the next edge; no timeout pulse.
  - tick to 0 -> timeout pulse, IDLE, en drops. zd_r has priority over an expiring tick in the same cycle.
  - Further presses and start edges are ignored.
- Foul clear: a start edge in IDLE while every en_sX is 0 clears foul in the cycle after entering ARMED. Fouls recorded before that start apply to the question being started; the clear applies from the next question onward.
- Arithmetic: time_left is 5-bit unsigned, decremented only when nonzero. It never wraps below 0.
- At most one en_sX is high at any time (one-hot or zero), including across transitions.

Decomposition:
- Shared package quiz_pkg: state enum (IDLE, ARMED, LOCKED), NUM_PLAYERS=4, PLAYER_W=2, TIME_W=5.
- Sub-module tick_gen: parameter TICK_DIV; inputs clk_count, rst, clr; output tick. The arbiter instantiates it once and drives clr on state entry.

Test Plan (TICK_DIV=4, BUZZ_TIME=3, ANSWER_TIME=2):
- Reset, then start edge, then s2 press -> en_s2=1 and winner=2 three cycles after the press edge; time_left=2; others 0. Pulse zd_r -> en_s2=0 next edge, busy=0, timeout=0.
- In ARMED, s1 and s3 rise in the same cycle -> winner=1, en_s1=1, en_s3 stays 0.
- s0 pressed in IDLE -> foul=4'b0001. Start, then s0 pressed -> no grant. s3 pressed -> en_s3=1, winner=3.
- Start with no presses -> time_left steps 3,2,1,0 at 4-cycle intervals; one-cycle timeout pulse; state IDLE.
- Grant s1, no zd_r -> after 8 cycles timeout pulse and en_s1=0. Separately, zd_r coincident with the expiring tick -> timeout stays 0.
- Assert rst while LOCKED with en_s2=1 -> en_s2=0 asynchronously; foul=0, time_left=0.

Source files
------------

// File: rtl/quiz_pkg.sv
// Shared types and sizes for the quiz responder front end.
package quiz_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int NUM_PLAYERS = 4;
    localparam int PLAYER_W    = 2;
    localparam int TIME_W      = 5;

    // Index of the lowest set bit; lower contestants win same-cycle ties.
    function automatic logic [PLAYER_W-1:0] lowest_set(input logic [NUM_PLAYERS-1:0] v);
        logic [PLAYER_W-1:0] idx;
        idx = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (v[i]) idx = PLAYER_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Countdown tick divider: one-cycle pulse every TICK_DIV cycles, restartable
// so the first tick after a clear lands exactly TICK_DIV cycles later.
module tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk_count,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) cnt_d = '0;
    end

    always_ff @(posedge clk_count or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/buzz_arbiter.sv
// Quiz buzzer lock-in: synchronises buttons, grants one contestant per
// question, runs buzz/answer countdowns and tracks early-press fouls.
module buzz_arbiter
    import quiz_pkg::*;
#(
    parameter int TICK_DIV    = 1000,
    parameter int BUZZ_TIME   = 20,
    parameter int ANSWER_TIME = 10
) (
    input  logic                   clk_count,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   s0,
    input  logic                   s1,
    input  logic                   s2,
    input  logic                   s3,
    input  logic                   zd_r,
    output logic                   en_s0,
    output logic                   en_s1,
    output logic                   en_s2,
    output logic                   en_s3,
    output logic [PLAYER_W-1:0]    winner,
    output logic [NUM_PLAYERS-1:0] foul,
    output logic [TIME_W-1:0]      time_left,
    output logic                   busy,
    output logic                   timeout
);

    localparam int NIN = NUM_PLAYERS + 1;
    localparam logic [TIME_W-1:0] BUZZ_INIT = TIME_W'(BUZZ_TIME);
    localparam logic [TIME_W-1:0] ANS_INIT  = TIME_W'(ANSWER_TIME);

    logic [NIN-1:0] raw_in;
    logic [NIN-1:0] meta_q;
    logic [NIN-1:0] sync_q;
    logic [NIN-1:0] prev_q;
    logic [NIN-1:0] rise;
    logic [NUM_PLAYERS-1:0] press;
    logic start_rise;

    state_t                 state_q, state_d;
    logic [PLAYER_W-1:0]    winner_q, winner_d;
    logic [NUM_PLAYERS-1:0] foul_q, foul_d;
    logic [NUM_PLAYERS-1:0] lockout_q, lockout_d;
    logic [TIME_W-1:0]      time_q, time_d;
    logic                   timeout_q, timeout_d;
    logic                   clr_pend_q, clr_pend_d;
    logic [NUM_PLAYERS-1:0] eligible;
    logic                   tick;
    logic                   expiring;
    logic                   entry;

    assign raw_in     = {start, s3, s2, s1, s0};
    assign rise       = sync_q & ~prev_q;
    assign press      = rise[NUM_PLAYERS-1:0];
    assign start_rise = rise[NUM_PLAYERS];

    always_ff @(posedge clk_count or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= raw_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_count (clk_count),
        .rst       (rst),
        .clr       (entry),
        .tick      (tick)
    );

    assign entry    = (state_d != state_q);
    assign expiring = tick && (time_q == TIME_W'(1));
    assign eligible = press & ~lockout_q;

    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        foul_d     = foul_q;
        lockout_d  = lockout_q;
        time_d     = time_q;
        timeout_d  = 1'b0;
        clr_pend_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                foul_d = foul_q | press;
                if (start_rise) begin
                    // Lockout snapshot keeps this question's fouls after the foul register clears.
                    state_d    = ARMED;
                    time_d     = BUZZ_INIT;
                    lockout_d  = foul_q | press;
                    clr_pend_d = 1'b1;
                end
            end
            ARMED: begin
                if (clr_pend_q) foul_d = '0;
                if (|eligible) begin
                    state_d  = LOCKED;
                    winner_d = lowest_set(eligible);
                    time_d   = ANS_INIT;
                end else if (expiring) begin
                    state_d   = IDLE;
                    time_d    = '0;
                    timeout_d = 1'b1;
                end else if (tick && time_q != '0) begin
                    time_d = time_q - TIME_W'(1);
                end
            end
            LOCKED: begin
                if (zd_r) begin
                    state_d = IDLE;
                    time_d  = '0;
                end else if (expiring) begin
                    state_d   = IDLE;
                    time_d    = '0;
                    timeout_d = 1'b1;
                end else if (tick && time_q != '0) begin
                    time_d = time_q - TIME_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                time_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_count or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            winner_q   <= '0;
            foul_q     <= '0;
            lockout_q  <= '0;
            time_q     <= '0;
            timeout_q  <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            winner_q   <= winner_d;
            foul_q     <= foul_d;
            lockout_q  <= lockout_d;
            time_q     <= time_d;
            timeout_q  <= timeout_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    // Enables decode straight from registered state, so they are one-hot by construction.
    logic [NUM_PLAYERS-1:0] en_vec;
    genvar gi;
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_en
        assign en_vec[gi] = (state_q == LOCKED) && (winner_q == PLAYER_W'(gi));
    end

    assign en_s0     = en_vec[0];
    assign en_s1     = en_vec[1];
    assign en_s2     = en_vec[2];
    assign en_s3     = en_vec[3];
    assign winner    = winner_q;
    assign foul      = foul_q;
    assign time_left = time_q;
    assign busy      = (state_q != IDLE);
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_buzz_arbiter.sv
// Directed bench for buzz_arbiter with a timeline-based reference model
// compared every cycle, plus hand-computed spot checks.
module tb_buzz_arbiter;

    localparam int TD = 4;
    localparam int BT = 3;
    localparam int AT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic s0 = 1'b0, s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
    logic zd_r = 1'b0;
    logic en_s0, en_s1, en_s2, en_s3;
    logic [1:0] winner;
    logic [3:0] foul;
    logic [4:0] time_left;
    logic busy, timeout;

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    buzz_arbiter #(.TICK_DIV(TD), .BUZZ_TIME(BT), .ANSWER_TIME(AT)) dut (
        .clk_count (clk),
        .rst       (rst),
        .start     (start),
        .s0        (s0),
        .s1        (s1),
        .s2        (s2),
        .s3        (s3),
        .zd_r      (zd_r),
        .en_s0     (en_s0),
        .en_s1     (en_s1),
        .en_s2     (en_s2),
        .en_s3     (en_s3),
        .winner    (winner),
        .foul      (foul),
        .time_left (time_left),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int en_vec();
        return int'({en_s3, en_s2, en_s1, en_s0});
    endfunction

    // Reference model: phases with entry time and window length; remaining time
    // and expiry follow from elapsed cycles rather than a counter.
    int m_phase = 0;           // 0 idle, 1 buzz window, 2 answer window
    int cyc = 0;
    int m_entry = 0;
    int m_arm_at = -10;
    int m_len = 0;
    int m_winner = 0;
    logic [3:0] m_foul = '0;
    logic [3:0] m_lock = '0;
    bit m_timeout = 1'b0;
    logic [4:0] r1 = '0, r2 = '0, r3 = '0;

    task automatic model_step();
        logic [4:0] ev;
        logic [3:0] pr, elig;
        bit expire;
        if (rst) begin
            m_phase = 0; m_winner = 0; m_foul = '0; m_lock = '0;
            m_timeout = 1'b0; r1 = '0; r2 = '0; r3 = '0; m_arm_at = -10;
            return;
        end
        cyc++;
        ev = r2 & ~r3;
        pr = ev[3:0];
        m_timeout = 1'b0;
        expire = (m_phase != 0) && ((cyc - m_entry) == m_len * TD);
        case (m_phase)
            0: begin
                m_foul = m_foul | pr;
                if (ev[4]) begin
                    m_lock = m_foul; m_phase = 1; m_entry = cyc; m_arm_at = cyc; m_len = BT;
                end
            end
            1: begin
                if (cyc == m_arm_at + 1) m_foul = '0;
                elig = pr & ~m_lock;
                if (elig != 0) begin
                    for (int i = 3; i >= 0; i--) if (elig[i]) m_winner = i;
                    m_phase = 2; m_entry = cyc; m_len = AT;
                end else if (expire) begin
                    m_phase = 0; m_timeout = 1'b1;
                end
            end
            default: begin
                if (zd_r) m_phase = 0;
                else if (expire) begin m_phase = 0; m_timeout = 1'b1; end
            end
        endcase
        r3 = r2; r2 = r1; r1 = {start, s3, s2, s1, s0};
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (!done) begin
            chk("m_en", en_vec(), (m_phase == 2) ? (1 << m_winner) : 0);
            chk("m_busy", int'(busy), (m_phase != 0) ? 1 : 0);
            chk("m_foul", int'(foul), int'(m_foul));
            chk("m_time", int'(time_left), (m_phase == 0) ? 0 : m_len - (cyc - m_entry) / TD);
            chk("m_timeout", int'(timeout), int'(m_timeout));
            if (m_phase == 2) chk("m_winner", int'(winner), m_winner);
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_q();
        start = 1'b1; wait_n(1);
        start = 1'b0; wait_n(2);
    endtask

    task automatic release_grant();
        zd_r = 1'b1; wait_n(1);
        zd_r = 1'b0; wait_n(3);
    endtask

    initial begin
        wait_n(3);
        chk("rst_en", en_vec(), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_foul", int'(foul), 0);
        chk("rst_time", int'(time_left), 0);
        chk("rst_winner", int'(winner), 0);
        rst = 1'b0;
        wait_n(2);

        // Grant s2, then judged release.
        start_q();
        chk("arm_busy", int'(busy), 1);
        chk("arm_time", int'(time_left), 3);
        s2 = 1'b1; wait_n(2);
        chk("s2_latency", int'(en_s2), 0);
        wait_n(1);
        chk("s2_en", en_vec(), 4'b0100);
        chk("s2_winner", int'(winner), 2);
        chk("s2_time", int'(time_left), 2);
        s2 = 1'b0;
        zd_r = 1'b1; wait_n(1); zd_r = 1'b0;
        chk("zd_en", en_vec(), 0);
        chk("zd_busy", int'(busy), 0);
        chk("zd_timeout", int'(timeout), 0);
        wait_n(3);

        // Same-cycle tie s1/s3.
        start_q();
        s1 = 1'b1; s3 = 1'b1; wait_n(3);
        chk("tie_winner", int'(winner), 1);
        chk("tie_en", en_vec(), 4'b0010);
        s1 = 1'b0; s3 = 1'b0;
        release_grant();

        // Foul in idle locks s0 out of the next question.
        s0 = 1'b1; wait_n(3);
        chk("foul_set", int'(foul), 4'b0001);
        s0 = 1'b0; wait_n(2);
        start_q();
        s0 = 1'b1; wait_n(3);
        chk("foul_nogrant", en_vec(), 0);
        chk("foul_busy", int'(busy), 1);
        s0 = 1'b0; s3 = 1'b1; wait_n(3);
        chk("foul_s3_en", en_vec(), 4'b1000);
        chk("foul_s3_winner", int'(winner), 3);
        s3 = 1'b0;
        release_grant();

        // Buzz window expiry with no presses.
        start_q();
        chk("bz_t3", int'(time_left), 3);
        wait_n(4); chk("bz_t2", int'(time_left), 2);
        wait_n(4); chk("bz_t1", int'(time_left), 1);
        wait_n(3); chk("bz_pre_to", int'(timeout), 0);
        wait_n(1);
        chk("bz_t0", int'(time_left), 0);
        chk("bz_to", int'(timeout), 1);
        chk("bz_idle", int'(busy), 0);
        wait_n(1); chk("bz_to_pulse", int'(timeout), 0);
        wait_n(2);

        // Answer window expiry after granting s1.
        start_q();
        s1 = 1'b1; wait_n(3); s1 = 1'b0;
        wait_n(7);
        chk("ans_hold", en_vec(), 4'b0010);
        chk("ans_pre_to", int'(timeout), 0);
        wait_n(1);
        chk("ans_to", int'(timeout), 1);
        chk("ans_en_drop", en_vec(), 0);
        wait_n(1); chk("ans_to_pulse", int'(timeout), 0);
        wait_n(2);

        // zd_r coincident with expiring tick suppresses timeout.
        start_q();
        s1 = 1'b1; wait_n(3); s1 = 1'b0;
        wait_n(7);
        zd_r = 1'b1; wait_n(1); zd_r = 1'b0;
        chk("zdx_to", int'(timeout), 0);
        chk("zdx_en", en_vec(), 0);
        wait_n(1); chk("zdx_to2", int'(timeout), 0);
        wait_n(2);

        // Press on the expiring buzz tick wins.
        start_q();
        wait_n(9);
        s0 = 1'b1; wait_n(3);
        chk("px_en", en_vec(), 4'b0001);
        chk("px_to", int'(timeout), 0);
        chk("px_time", int'(time_left), 2);
        s0 = 1'b0;
        release_grant();

        // Asynchronous reset while locked.
        start_q();
        s2 = 1'b1; wait_n(3);
        chk("ar_pre_en", en_vec(), 4'b0100);
        #2 rst = 1'b1;
        #1;
        chk("ar_en", en_vec(), 0);
        chk("ar_foul", int'(foul), 0);
        chk("ar_time", int'(time_left), 0);
        chk("ar_busy", int'(busy), 0);
        s2 = 1'b0;
        wait_n(2);
        rst = 1'b0;
        wait_n(3);

        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
